uart_tx: RTL

Baud-rate UART transmitter with a small input FIFO, the transmit counterpart of the existing UART receiver in the builtin UART RTL device. Accepts parallel bytes over a valid/ready handshake, buffers them, and serialises each as an 8N1/8N2 frame (start bit low, data LSB first, stop bit(s) high) on a single line. It sits between the emulated device's register interface and the RX pin of the peer receiver.

---
 rtl/uart_tx_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings common to the transmitter and receiver,
// and the bit-period / counter-width derivations used by both.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b11,
        ST_STOP  = 2'b10
    } uart_state_e;

    localparam int DEFAULT_CLK_FREQ     = 1000000;
    localparam int DEFAULT_BAUD_RATE    = 9600;
    localparam int DEFAULT_PAYLOAD_BITS = 8;

    function automatic int bit_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int clk_cnt_width(input int period);
        return $clog2(period) + 1;
    endfunction

    function automatic int bit_cnt_width(input int payload_bits);
        return $clog2(payload_bits) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register
            // samples its inputs from before the edge, independent of statement order.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries
    // are valid, and leaving the array out of reset lets it map onto plain RAM cells.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes from a valid/ready port in a small FIFO and serialises
// each one as start bit, LSB-first payload and one or two stop bits on a registered line.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int Param_BaurdRate   = DEFAULT_BAUD_RATE,
    parameter int Param_ClkFreq     = DEFAULT_CLK_FREQ,
    parameter int Param_PayloadBits = DEFAULT_PAYLOAD_BITS,
    parameter int Param_StopBits    = 1,
    parameter int Param_FifoDepth   = 4
) (
    input  logic                         IO_Clk_I,
    input  logic                         IO_Rst_I,
    input  logic                         IO_TxValid_I,
    input  logic [Param_PayloadBits-1:0] IO_TxData_I,
    output logic                         IO_TxReady_O,
    output logic                         IO_Tx_O,
    output logic                         IO_TxBusy_O,
    output logic                         IO_TxDone_O
);

    localparam int P     = bit_period(Param_ClkFreq, Param_BaurdRate);
    localparam int CNT_W = clk_cnt_width(P);
    localparam int BIT_W = bit_cnt_width(Param_PayloadBits);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(Param_PayloadBits - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(Param_StopBits - 1);

    uart_state_e                  state_q, state_d;
    logic [CNT_W-1:0]             clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [Param_PayloadBits-1:0] shift_q, shift_d;
    logic                         tx_q, tx_d;
    logic                         done_q, done_d;

    logic                         fifo_pop;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic [Param_PayloadBits-1:0] fifo_head;
    logic                         bit_end;

    uart_tx_fifo #(
        .DEPTH (Param_FifoDepth),
        .WIDTH (Param_PayloadBits)
    ) u_fifo (
        .clk_i   (IO_Clk_I),
        .rst_i   (IO_Rst_I),
        .push_i  (IO_TxValid_I),
        .data_i  (IO_TxData_I),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bit_end = (clk_cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default before the case statement so
        // no path leaves a signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_head;
                    clk_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == STOP_LAST) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        // Chain straight into the next start bit so queued frames abut.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_head;
                            state_d  = ST_START;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line register is loaded with the level the next state drives.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge IO_Clk_I or posedge IO_Rst_I) begin
        if (IO_Rst_I) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign IO_Tx_O      = tx_q;
    assign IO_TxDone_O  = done_q;
    assign IO_TxReady_O = !fifo_full;
    assign IO_TxBusy_O  = (state_q != ST_IDLE) || !fifo_empty;

endmodule
